sprite_pixel_writer: RTL and testbench
======================================

Name: sprite_pixel_writer

Overview:
Downstream stage of the sprite pixel sequencer. Per sprite pixel, it combines:
- the pixel colour loaded from sprite ROM,
- the sprite's on-screen origin,
- the sequencer's local pixel coordinates (game_x/game_y, 0..14).

Opaque, on-screen pixels become frame-buffer addresses. These are buffered in a small FIFO and drained to the frame-buffer arbiter through a req/ack handshake. When the sprite has fully drained, the block signals completion to the sprite scheduler.

Parameters:
- SCREEN_W, 320, frame width in pixels
- SCREEN_H, 240, frame height in pixels
- ADDR_W, 17, frame-buffer address width (must cover SCREEN_W*SCREEN_H)
- COLOR_W, 8, pixel colour width
- TRANSP, 8'h00, colour index treated as transparent (never written)
- FIFO_DEPTH, 4, write-buffer entries (power of two, at least 2)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- origin_ld  in  1  latch sprite_x/sprite_y (pulsed together with sequencer Run)
- sprite_x  in  9  screen x of sprite pixel (0,0)
- sprite_y  in  8  screen y of sprite pixel (0,0)
- ld_reg  in  1  latch pixel_in into pixel register
- pixel_in  in  COLOR_W  sprite ROM read data
- write_out  in  1  current pixel valid at game_x/game_y
- game_x  in  4  local column 0..14
- game_y  in  4  local row 0..14
- next_s  in  1  last pixel of sprite issued
- fb_req  out  1  write request to arbiter
- fb_addr  out  ADDR_W  write address (head of FIFO)
- fb_data  out  COLOR_W  write colour (head of FIFO)
- fb_ack  in  1  arbiter accepted the current request
- busy  out  1  FIFO non-empty or done pending
- done  out  1  one-cycle pulse: sprite fully written
- overflow  out  1  sticky: a pixel was dropped on a full FIFO
- clear_flags  in  1  clears overflow

Behaviour:
- Reset: FIFO emptied, pointers/count 0, drain FSM to IDLE, pixel and origin registers 0. fb_req, fb_addr, fb_data, busy, done and overflow are all 0.
- origin_ld: registers sprite_x/sprite_y at the clock edge. It is not expected to coincide with write_out; if it does, the current write uses the old origin.
- ld_reg: pix_reg <= pixel_in at the edge. ld_reg and write_out in the same cycle: write_out uses the old pix_reg.
- Write evaluation, in any cycle with write_out=1:
  - sx = org_x + game_x, computed 10 bits wide; sy = org_y + game_y, computed 9 bits wide.
  - Skip (no push, no error) if pix_reg==TRANSP, sx>=SCREEN_W, or sy>=SCREEN_H.
  - Otherwise push {addr = sy*SCREEN_W + sx truncated to ADDR_W, pix_reg} at the edge.
  - The multiply is by a constant; a shift/add implementation is acceptable.
- Full FIFO on a push: the pixel is dropped and overflow is set (sticky until clear_flags or Reset). Overflow set and clear_flags in the same cycle: set wins.
- Push and pop in the same cycle: both occur, count unchanged. This also applies when the FIFO is full, since the pop frees a slot.
- Drain FSM, registered:
  - IDLE: fb_req=0. Go to REQ when the FIFO is non-empty.
  - REQ: fb_req=1, with fb_addr/fb_data equal to the FIFO head and held stable until fb_ack.
  - fb_ack in REQ: pop at the edge. Stay in REQ if an entry remains after the pop, including an entry pushed that same cycle; otherwise go to IDLE.
  - fb_ack in IDLE is ignored.
- Latency:
  - write_out in cycle N means the entry is visible in N+1 and fb_req rises in N+2 (from IDLE).
  - Back-to-back acks give one write per cycle.
- Completion:
  - next_s sets done_pend. next_s is sampled regardless of write_out and is processed after that cycle's push.
  - When done_pend=1, the FIFO is empty and the FSM is IDLE, pulse done for one cycle and clear done_pend.
  - next_s arriving when already empty gives done exactly 2 cycles later (done_pend set at the edge, done asserted the following cycle).
  - A second next_s while done_pend=1 is merged, producing a single done pulse.
- busy = FIFO non-empty OR done_pend OR state==REQ.
- Reset mid-sprite: all entries are discarded with no further fb_req, and no done is produced.

Decomposition:
- Shared package sprite_pkg, holding:
  - SCREEN_W, SCREEN_H, ADDR_W, COLOR_W, TRANSP;
  - fb_wr_t struct {addr, data};
  - drain state enum {IDLE, REQ}.
- One natural sub-module: sync_fifo, parameterised on width and depth. It provides push, pop, head, full, empty and count; simultaneous push/pop is legal even when full.

Test Plan:
- Basic write: origin (100,50), pixel 8'h1F, write_out at game (3,2) -> fb_addr = 52*320+103 = 16743, fb_data = 8'h1F, fb_req rising 2 cycles later, dropped after ack.
- Transparency/clipping: pixel 8'h00 at (0,0) -> no fb_req. Origin (310,230), opaque pixels at game (9,0) and (10,0) -> first written at x=319, second skipped; likewise sy=240 skipped.
- Full sprite under the real cadence (write_out every 3 cycles, 225 opaque pixels, fb_ack held 1) -> 225 writes in raster order, overflow=0, one done pulse after the last ack.
- Backpressure: fb_ack held 0 for 20 cycles during a sprite -> FIFO fills to 4, later pixels dropped, overflow=1, fb_addr stable while waiting. clear_flags -> overflow=0.
- Simultaneous events: write_out with the FIFO full and fb_ack=1 -> push accepted, count stays 4. next_s with an empty FIFO -> done 2 cycles later. Two next_s pulses -> one done.
- Reset mid-drain: Reset with 3 entries queued -> fb_req=0 next cycle, busy=0, no done, and a new sprite afterwards operates normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite pixel writer.
//   - Screen geometry, frame-buffer address and colour widths, and the
//     transparent colour index.
//   - fb_wr_t: a single frame-buffer write {addr, data}.
//   - drain_state_e: states of the write-drain FSM.
//   - fb_addr_of(): linear frame-buffer address of an on-screen pixel.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned COLOR_W  = 8;

    localparam logic [COLOR_W-1:0] TRANSP = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] data;
    } fb_wr_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

    // Row-major address. The caller has already clipped sx/sy to the screen,
    // so the result always fits in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] fb_addr_of(input logic [9:0] sx,
                                                     input logic [8:0] sy);
        return ADDR_W'(sy) * ADDR_W'(SCREEN_W) + ADDR_W'(sx);
    endfunction

endpackage

// File: rtl/sprite_pixel_writer_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read.
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i/wdata_i write an entry (ignored when full unless popping too)
//   pop_i          remove the head entry (ignored when empty)
//   head_o         oldest entry (undefined contents while empty)
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries, 0..DEPTH
// Push and pop in the same cycle are both honoured, also when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot this push needs, so a full FIFO still accepts it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage is not reset; the pointers and count alone define which
    // entries are valid, and leaving the array unreset keeps it plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sprite_pixel_writer.sv
// sprite_pixel_writer: turns sequencer pixels into frame-buffer writes.
//   Clk, Reset               clock, synchronous active-high reset
//   origin_ld, sprite_x/y    latch the sprite's screen origin
//   ld_reg, pixel_in         latch the sprite ROM colour
//   write_out, game_x/y      current pixel valid at local coordinates
//   next_s                   last pixel of the sprite has been issued
//   fb_req/fb_addr/fb_data   write request to the frame-buffer arbiter
//   fb_ack                   arbiter accepted the current request
//   busy                     writes or a completion still outstanding
//   done                     one-cycle pulse when the sprite has drained
//   overflow, clear_flags    sticky dropped-pixel flag and its clear
module sprite_pixel_writer
    import sprite_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               origin_ld,
    input  logic [8:0]         sprite_x,
    input  logic [7:0]         sprite_y,
    input  logic               ld_reg,
    input  logic [COLOR_W-1:0] pixel_in,
    input  logic               write_out,
    input  logic [3:0]         game_x,
    input  logic [3:0]         game_y,
    input  logic               next_s,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ack,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    input  logic               clear_flags
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_e       state_q;
    logic [8:0]         org_x_q;
    logic [7:0]         org_y_q;
    logic [COLOR_W-1:0] pix_q;
    logic               overflow_q;
    logic               done_pend_q;
    logic               done_q;

    logic [9:0]         sx;
    logic [8:0]         sy;
    logic               pix_ok;
    logic               push;
    logic               pop;
    logic               drop;
    logic               fire;
    fb_wr_t             wr_entry;
    fb_wr_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // One extra bit on each sum so sprites hanging off the right or bottom
    // edge are clipped instead of wrapping back onto the screen.
    assign sx = {1'b0, org_x_q} + {6'b0, game_x};
    assign sy = {1'b0, org_y_q} + {5'b0, game_y};

    assign pix_ok = write_out && (pix_q != TRANSP)
                 && (32'(sx) < SCREEN_W) && (32'(sy) < SCREEN_H);

    assign pop  = (state_q == REQ) && fb_ack;
    assign push = pix_ok && (!fifo_full || pop);
    assign drop = pix_ok && fifo_full && !pop;

    // Completion waits until every queued write has been accepted.
    assign fire = done_pend_q && fifo_empty && (state_q == IDLE);

    assign wr_entry.addr = fb_addr_of(sx, sy);
    assign wr_entry.data = pix_q;

    sync_fifo #(
        .WIDTH ($bits(fb_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every register here updates with non-blocking assignments so all
    // of them see the same pre-edge values within one clock.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            org_x_q     <= '0;
            org_y_q     <= '0;
            pix_q       <= '0;
            overflow_q  <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (origin_ld) begin
                org_x_q <= sprite_x;
                org_y_q <= sprite_y;
            end
            if (ld_reg) begin
                pix_q <= pixel_in;
            end

            // Setting wins over clearing so a drop is never lost.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_flags) begin
                overflow_q <= 1'b0;
            end

            // A next_s that lands while a completion is already pending is
            // folded into that completion.
            if (fire) begin
                done_pend_q <= 1'b0;
            end else if (next_s) begin
                done_pend_q <= 1'b1;
            end
            done_q <= fire;

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) state_q <= REQ;
                end
                REQ: begin
                    // Stay while anything remains after this pop, counting
                    // an entry pushed in the same cycle.
                    if (pop && !((fifo_count > CNT_W'(1)) || push)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_req   = (state_q == REQ);
    // Masked while empty so stale storage never appears on the bus.
    assign fb_addr  = fifo_empty ? '0 : head.addr;
    assign fb_data  = fifo_empty ? '0 : head.data;
    assign busy     = !fifo_empty || done_pend_q || (state_q == REQ);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sprite_pixel_writer.sv
// Directed self-checking bench for sprite_pixel_writer.
module tb_sprite_pixel_writer;

    logic        Clk;
    logic        Reset;
    logic        origin_ld;
    logic [8:0]  sprite_x;
    logic [7:0]  sprite_y;
    logic        ld_reg;
    logic [7:0]  pixel_in;
    logic        write_out;
    logic [3:0]  game_x;
    logic [3:0]  game_y;
    logic        next_s;
    logic        fb_req;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ack;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        clear_flags;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [16:0] log_addr[$];
    logic [7:0]  log_data[$];

    sprite_pixel_writer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .origin_ld   (origin_ld),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .ld_reg      (ld_reg),
        .pixel_in    (pixel_in),
        .write_out   (write_out),
        .game_x      (game_x),
        .game_y      (game_y),
        .next_s      (next_s),
        .fb_req      (fb_req),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_ack      (fb_ack),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .clear_flags (clear_flags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record accepted writes and completion pulses mid-cycle.
    always @(negedge Clk) begin
        if (!Reset && fb_req && fb_ack) begin
            log_addr.push_back(fb_addr);
            log_data.push_back(fb_data);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_origin(input int x, input int y);
        origin_ld = 1'b1;
        sprite_x  = 9'(x);
        sprite_y  = 8'(y);
        tick();
        origin_ld = 1'b0;
    endtask

    task automatic load_pix(input logic [7:0] p);
        ld_reg   = 1'b1;
        pixel_in = p;
        tick();
        ld_reg   = 1'b0;
    endtask

    task automatic write_px(input int gx, input int gy, input bit last);
        write_out = 1'b1;
        game_x    = 4'(gx);
        game_y    = 4'(gy);
        next_s    = last;
        tick();
        write_out = 1'b0;
        next_s    = 1'b0;
    endtask

    initial begin
        int d0;
        int errs;
        logic [16:0] exp_a;
        logic [16:0] bp_exp [5];

        Reset = 1'b1; origin_ld = 1'b0; sprite_x = '0; sprite_y = '0;
        ld_reg = 1'b0; pixel_in = '0; write_out = 1'b0; game_x = '0;
        game_y = '0; next_s = 1'b0; fb_ack = 1'b0; clear_flags = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_fb_req",   32'(fb_req),   0);
        check("rst_fb_addr",  32'(fb_addr),  0);
        check("rst_fb_data",  32'(fb_data),  0);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_overflow", 32'(overflow), 0);
        Reset = 1'b0;
        tick();

        // Basic write: origin (100,50), pixel 1F at game (3,2)
        set_origin(100, 50);
        load_pix(8'h1F);
        write_px(3, 2, 1'b0);
        check("basic_req_n1",  32'(fb_req),  0);
        check("basic_addr_n1", 32'(fb_addr), 16743);
        check("basic_busy_n1", 32'(busy),    1);
        tick();
        check("basic_req_n2",  32'(fb_req),  1);
        check("basic_addr_n2", 32'(fb_addr), 16743);
        check("basic_data_n2", 32'(fb_data), 32'h1F);
        fb_ack = 1'b1;
        tick();
        fb_ack = 1'b0;
        check("basic_req_after_ack", 32'(fb_req), 0);
        check("basic_busy_after",    32'(busy),   0);

        // Transparent pixel: never requested
        load_pix(8'h00);
        write_px(0, 0, 1'b0);
        tick();
        tick();
        check("transp_req",  32'(fb_req), 0);
        check("transp_busy", 32'(busy),   0);

        // Clipping on the right edge: x=319 written, x=320 skipped
        set_origin(310, 230);
        load_pix(8'h55);
        fb_ack = 1'b1;
        write_px(9, 0, 1'b0);
        write_px(10, 0, 1'b0);
        check("clip_req",  32'(fb_req),  1);
        check("clip_addr", 32'(fb_addr), 73919);
        check("clip_data", 32'(fb_data), 32'h55);
        tick();
        check("clip_x320_req",  32'(fb_req), 0);
        check("clip_x320_busy", 32'(busy),   0);
        // Bottom edge: sy=240 skipped
        write_px(0, 10, 1'b0);
        tick();
        tick();
        check("clip_y240_req",  32'(fb_req), 0);
        check("clip_y240_busy", 32'(busy),   0);
        check("clip_overflow",  32'(overflow), 0);

        // Full 15x15 sprite at the real cadence, ack held high
        log_addr.delete();
        log_data.delete();
        set_origin(20, 10);
        d0 = done_cnt;
        for (int i = 0; i < 225; i++) begin
            load_pix(8'((i % 255) + 1));
            write_px(i % 15, i / 15, i == 224);
            tick();
        end
        for (int k = 0; k < 30 && done_cnt == d0; k++) tick();
        tick();
        tick();
        tick();
        check("sprite_done_cnt", 32'(done_cnt - d0), 1);
        check("sprite_writes",   32'(log_addr.size()), 225);
        errs = 0;
        if (log_addr.size() == 225) begin
            for (int i = 0; i < 225; i++) begin
                exp_a = 17'((10 + i / 15) * 320 + 20 + i % 15);
                if (log_addr[i] !== exp_a || log_data[i] !== 8'((i % 255) + 1)) errs++;
            end
        end
        check("sprite_order_errs", 32'(errs), 0);
        check("sprite_overflow",   32'(overflow), 0);
        check("sprite_busy",       32'(busy), 0);
        fb_ack = 1'b0;

        // Backpressure: six pixels, only four fit
        log_addr.delete();
        log_data.delete();
        set_origin(5, 1);
        load_pix(8'h33);
        for (int k = 0; k < 6; k++) write_px(k, 0, 1'b0);
        check("bp_overflow", 32'(overflow), 1);
        check("bp_req",      32'(fb_req),   1);
        check("bp_addr0",    32'(fb_addr),  325);
        for (int k = 0; k < 20; k++) tick();
        check("bp_addr_stable", 32'(fb_addr), 325);
        check("bp_data_stable", 32'(fb_data), 32'h33);
        check("bp_req_held",    32'(fb_req),  1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("bp_clear", 32'(overflow), 0);

        // Push while full with a simultaneous pop
        fb_ack = 1'b1;
        write_px(6, 0, 1'b0);
        fb_ack = 1'b0;
        check("sim_req",      32'(fb_req),   1);
        check("sim_addr",     32'(fb_addr),  326);
        check("sim_overflow", 32'(overflow), 0);
        fb_ack = 1'b1;
        for (int k = 0; k < 10 && busy; k++) tick();
        fb_ack = 1'b0;
        check("bp_drained", 32'(busy), 0);
        check("bp_writes",  32'(log_addr.size()), 5);
        bp_exp = '{17'd325, 17'd326, 17'd327, 17'd328, 17'd331};
        errs = 0;
        if (log_addr.size() == 5) begin
            for (int i = 0; i < 5; i++)
                if (log_addr[i] !== bp_exp[i] || log_data[i] !== 8'h33) errs++;
        end
        check("bp_order_errs", 32'(errs), 0);

        // next_s with an empty FIFO: done exactly two cycles later
        d0 = done_cnt;
        next_s = 1'b1;
        tick();
        next_s = 1'b0;
        check("empty_done_n1", 32'(done), 0);
        check("empty_busy_n1", 32'(busy), 1);
        tick();
        check("empty_done_n2", 32'(done), 1);
        tick();
        check("empty_done_n3", 32'(done), 0);
        check("empty_busy_n3", 32'(busy), 0);
        check("empty_done_cnt", 32'(done_cnt - d0), 1);

        // Two back-to-back next_s pulses merge into one done
        d0 = done_cnt;
        next_s = 1'b1;
        tick();
        tick();
        next_s = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("merge_done_cnt", 32'(done_cnt - d0), 1);

        // Reset with three entries queued
        set_origin(0, 0);
        load_pix(8'h44);
        write_px(0, 0, 1'b0);
        write_px(1, 0, 1'b0);
        write_px(2, 0, 1'b1);
        tick();
        check("rstmid_pre_req", 32'(fb_req), 1);
        d0 = done_cnt;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rstmid_req",  32'(fb_req), 0);
        check("rstmid_busy", 32'(busy),   0);
        for (int k = 0; k < 6; k++) tick();
        check("rstmid_no_done", 32'(done_cnt - d0), 0);
        check("rstmid_req_later", 32'(fb_req), 0);

        // A fresh sprite after reset works normally
        log_addr.delete();
        log_data.delete();
        set_origin(1, 1);
        load_pix(8'h7E);
        fb_ack = 1'b1;
        d0 = done_cnt;
        write_px(0, 0, 1'b1);
        for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
        fb_ack = 1'b0;
        check("post_done",   32'(done_cnt - d0), 1);
        check("post_writes", 32'(log_addr.size()), 1);
        if (log_addr.size() == 1) begin
            check("post_addr", 32'(log_addr[0]), 321);
            check("post_data", 32'(log_data[0]), 32'h7E);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
